// File: rtl/wb_pkg.sv
// Shared types for the register writeback slice: data/address widths and the load FIFO entry.
// Optional scoreboard feature is selected in the top via WB_SCOREBOARD_EN.
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Load-result FIFO: DEPTH entries of wb_entry_t, push/pop in one cycle, count-based full/empty.
// Latency 1 (push visible at head next cycle); no internal backpressure, caller gates push on count.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  wb_entry_t                i_push_dat,
    input  logic                     i_pop,
    output wb_entry_t                o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic [REG_AW-1:0]        i_probe_rd,
    output logic                     o_probe_hit
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    wb_entry_t     r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_comb begin
        o_probe_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < r_count) && (r_mem[r_rd_ptr + PW'(i)].rd == i_probe_rd))
                o_probe_hit = 1'b1;
        end
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU results and FIFO-buffered load results onto the single register file write port.
// Latency 1 cycle to AD3/WE3/WD3; loads backpressured via ld_ready_o, ALU via stall_o. Macro: WB_SCOREBOARD_EN.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int WIDTH     = 5,
    parameter int DEPTH     = 4,
    parameter int MAX_WAIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid_i,
    input  logic [WIDTH-1:0]         alu_rd_i,
    input  logic [DATAWIDTH-1:0]     alu_data_i,
    input  logic                     ld_valid_i,
    output logic                     ld_ready_o,
    input  logic [WIDTH-1:0]         ld_rd_i,
    input  logic [DATAWIDTH-1:0]     ld_data_i,
`ifdef WB_SCOREBOARD_EN
    input  logic                     ld_issue_i,
    input  logic [WIDTH-1:0]         ld_issue_rd_i,
    input  logic [WIDTH-1:0]         rs1_i,
    input  logic [WIDTH-1:0]         rs2_i,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o,
`endif
    output logic [WIDTH-1:0]         AD3,
    output logic                     WE3,
    output logic [DATAWIDTH-1:0]     WD3,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WIDTH-1:0]     r_ad3;
    logic                 r_we3;
    logic [DATAWIDTH-1:0] r_wd3;
    logic                 r_stall;
    logic [WW-1:0]        r_wait_cnt;
    logic [WW-1:0]        w_wait_nxt;
    logic [CW-1:0]        w_count;
    wb_entry_t            w_head;
    wb_entry_t            w_push_dat;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_alu_win;
    logic                 w_nonempty;
    logic                 w_alu_hit;

    assign w_nonempty = (w_count != '0);
    assign ld_ready_o = (w_count < CW'(DEPTH));
    assign w_push     = ld_valid_i & ld_ready_o & (ld_rd_i != '0);
    assign w_alu_win  = alu_valid_i & (alu_rd_i != '0) & ~r_stall;
    assign w_pop      = ~w_alu_win & w_nonempty;
    assign w_push_dat = '{rd: ld_rd_i, data: ld_data_i};

    wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .i_probe_rd (alu_rd_i),
        .o_probe_hit(w_alu_hit)
    );

    // The forced pop during stall guarantees the counter never passes MAX_WAIT.
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (w_pop)           w_wait_nxt = '0;
        else if (w_nonempty) w_wait_nxt = r_wait_cnt + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ad3      <= '0;
            r_we3      <= 1'b0;
            r_wd3      <= '0;
            r_stall    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            r_stall    <= (w_wait_nxt == WW'(MAX_WAIT));
            r_we3      <= w_alu_win | w_pop;
            if (w_alu_win) begin
                r_ad3 <= alu_rd_i;
                r_wd3 <= alu_data_i;
            end else if (w_pop) begin
                r_ad3 <= w_head.rd;
                r_wd3 <= w_head.data;
            end
        end
    end

    assign AD3        = r_ad3;
    assign WE3        = r_we3;
    assign WD3        = r_wd3;
    assign stall_o    = r_stall;
    assign fifo_cnt_o = w_count;

    // An ALU write overtaking a queued load to the same rd would leave stale data behind.
    a_no_alu_over_load: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_alu_win && w_alu_hit));

`ifdef WB_SCOREBOARD_EN
    logic [(1<<WIDTH)-1:0] r_busy;
    logic [(1<<WIDTH)-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)                               w_busy_nxt[w_head.rd] = 1'b0;
        if (ld_issue_i && ld_issue_rd_i != '0)   w_busy_nxt[ld_issue_rd_i] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign rs1_busy_o = r_busy[rs1_i];
    assign rs2_busy_o = r_busy[rs2_i];
`endif
endmodule
